// File: rtl/irq_responder_pkg.sv
// Shared definitions for the interrupt responder: FSM encoding, ID width,
// default vector window and the window mask helper.
package irq_responder_pkg;

    localparam int IRQ_ID_W     = 5;
    localparam int NUM_PERI     = 16;
    localparam int DEF_IRQ_BASE = 32 - NUM_PERI;
    localparam int DEF_IRQ_NUM  = NUM_PERI;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [31:0] window_mask(input int base, input int num);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (int'(i) >= base) && (int'(i) < base + num);
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_responder_if.sv
// Controller/core-side signal bundle of the responder. The slave modport is the
// responder itself; the master modport is the controller/core environment.
interface irq_responder_if;
    import irq_responder_pkg::*;

    logic [31:0]         irq_i;
    logic                mask_we_i;
    logic [31:0]         mask_wdata_i;
    logic [31:0]         mask_o;
    logic                irq_req_o;
    logic [IRQ_ID_W-1:0] irq_id_o;
    logic                core_take_i;
    logic                core_mret_i;
    logic                irq_ack_o;
    logic [IRQ_ID_W-1:0] irq_ack_id_o;
    logic                busy_o;

    modport slave (
        input  irq_i, mask_we_i, mask_wdata_i, core_take_i, core_mret_i,
        output mask_o, irq_req_o, irq_id_o, irq_ack_o, irq_ack_id_o, busy_o
    );

    modport master (
        output irq_i, mask_we_i, mask_wdata_i, core_take_i, core_mret_i,
        input  mask_o, irq_req_o, irq_id_o, irq_ack_o, irq_ack_id_o, busy_o
    );

endinterface

// File: rtl/irq_responder_prio_sel.sv
// Combinational selector: searches the window downward from a start index,
// wrapping from BASE to the top; a start at the top gives fixed priority.
module irq_prio_sel
    import irq_responder_pkg::*;
#(
    parameter int BASE = DEF_IRQ_BASE,
    parameter int NUM  = DEF_IRQ_NUM
) (
    input  logic [31:0]         pending,
    input  logic [31:0]         window,
    input  logic [IRQ_ID_W-1:0] start,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    logic [31:0]         masked;
    int                  s_off;
    int                  off;
    logic [IRQ_ID_W-1:0] idx;

    assign masked = pending & window;

    always_comb begin
        valid = 1'b0;
        id    = '0;
        off   = 0;
        idx   = '0;
        s_off = int'(start) - BASE;
        for (int unsigned k = 0; k < NUM; k++) begin
            off = s_off - int'(k);
            if (off < 0) off = off + NUM;
            idx = IRQ_ID_W'(BASE + off);
            if (!valid && masked[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/irq_responder.sv
// Core-side end of the level/ack interrupt handshake. Optional macro
// IRQ_ROUND_ROBIN_EN rotates priority past the most recently acknowledged line.
module irq_responder
    import irq_responder_pkg::*;
#(
    parameter int IRQ_BASE = DEF_IRQ_BASE,
    parameter int IRQ_NUM  = DEF_IRQ_NUM
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    irq_responder_if.slave  bus
);

    localparam logic [31:0]         WINDOW  = window_mask(IRQ_BASE, IRQ_NUM);
    localparam logic [IRQ_ID_W-1:0] TOP_ID  = IRQ_ID_W'(IRQ_BASE + IRQ_NUM - 1);
    localparam logic [IRQ_ID_W-1:0] BASE_ID = IRQ_ID_W'(IRQ_BASE);

    state_t              state_q;
    logic [31:0]         mask_q;
    logic                req_q;
    logic [IRQ_ID_W-1:0] id_q;
    logic                ack_q;
    logic [IRQ_ID_W-1:0] ack_id_q;
    logic                busy_q;

    logic [31:0]         pending;
    logic [IRQ_ID_W-1:0] start_id;
    logic                sel_valid;
    logic [IRQ_ID_W-1:0] sel_id;

    assign pending = bus.irq_i & mask_q & WINDOW;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IRQ_ID_W-1:0] last_id_q;
    assign start_id = (last_id_q == BASE_ID) ? TOP_ID : last_id_q - 1'b1;
`else
    assign start_id = TOP_ID;
`endif

    irq_prio_sel #(
        .BASE (IRQ_BASE),
        .NUM  (IRQ_NUM)
    ) u_sel (
        .pending (pending),
        .window  (WINDOW),
        .start   (start_id),
        .valid   (sel_valid),
        .id      (sel_id)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            req_q    <= 1'b0;
            id_q     <= '0;
            ack_q    <= 1'b0;
            ack_id_q <= '0;
            busy_q   <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
            last_id_q <= TOP_ID;
`endif
        end else begin
            if (bus.mask_we_i) mask_q <= bus.mask_wdata_i;
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        id_q    <= sel_id;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // take has priority over a simultaneous withdraw
                    if (bus.core_take_i) begin
                        req_q    <= 1'b0;
                        ack_q    <= 1'b1;
                        ack_id_q <= id_q;
                        busy_q   <= 1'b1;
                        state_q  <= SERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
                        last_id_q <= id_q;
`endif
                    end else if (!pending[id_q]) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SERVICE: begin
                    if (bus.core_mret_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mask_o       = mask_q;
    assign bus.irq_req_o    = req_q;
    assign bus.irq_id_o     = id_q;
    assign bus.irq_ack_o    = ack_q;
    assign bus.irq_ack_id_o = ack_id_q;
    assign bus.busy_o       = busy_q;

endmodule
